// File: rtl/leaf_out_arbiter_pkg.sv
// Shared definitions for the leaf output arbiter: stream/field widths,
// packet bit offsets, the packet struct and the per-port credit limit.
package leaf_pkg;

  localparam int NUM_OUT_PORTS = 4;
  localparam int PAYLOAD_BITS  = 32;
  localparam int NUM_LEAF_BITS = 5;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

  localparam int CREDIT_MAX = 64;
  localparam int CRD_BITS   = 7;
  localparam int PTR_BITS   = $clog2(NUM_OUT_PORTS);

  // Field offsets, LSB first: payload, seq, dest port, dest leaf, valid.
  localparam int PAYLOAD_LSB = 0;
  localparam int SEQ_LSB     = PAYLOAD_LSB + PAYLOAD_BITS;
  localparam int DPORT_LSB   = SEQ_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB    = DPORT_LSB + NUM_PORT_BITS;
  localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] dport;
    logic [NUM_ADDR_BITS-1:0] seq;
    logic [PAYLOAD_BITS-1:0]  payload;
  } packet_t;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Bundle of the arbiter's data-path signals: user output streams,
// destination configuration, credit return and the bft packet output.
// master: the environment (user kernel, config, bft side)
// slave:  the arbiter
interface leaf_out_arbiter_if;
  import leaf_pkg::*;

  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_OUT_PORTS-1:0]              vld_user;
  logic [NUM_OUT_PORTS-1:0]              ack_user;
  logic                                  cfg_we;
  logic [NUM_PORT_BITS-1:0]              cfg_port;
  logic [NUM_LEAF_BITS-1:0]              cfg_leaf;
  logic [NUM_PORT_BITS-1:0]              cfg_dport;
  logic                                  crd_vld;
  logic [NUM_PORT_BITS-1:0]              crd_port;
  logic [CRD_BITS-1:0]                   crd_amt;
  logic                                  bft_rdy;
  logic [PACKET_BITS-1:0]                dout_bft;

  modport master (
    output din_user, vld_user, cfg_we, cfg_port, cfg_leaf, cfg_dport,
           crd_vld, crd_port, crd_amt, bft_rdy,
    input  ack_user, dout_bft
  );

  modport slave (
    input  din_user, vld_user, cfg_we, cfg_port, cfg_leaf, cfg_dport,
           crd_vld, crd_port, crd_amt, bft_rdy,
    output ack_user, dout_bft
  );
endinterface

// File: rtl/leaf_out_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first set req bit at or
// above ptr, wrapping around.
// req   : request vector
// ptr   : highest-priority index this cycle
// gnt   : one-hot grant (zero when nothing requests)
// found : some request was granted
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 found
);

  int idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Shares a leaf's single bft injection channel among the user output
// streams. Each free slot, one eligible stream (valid, configured, has
// credit) is picked round-robin, acknowledged combinationally, and its
// word is packed with the port's destination and sequence number into the
// registered packet output.
// clk_bft : clock
// reset   : asynchronous active-low reset
// bus     : user streams, config, credit return and bft packet output
module leaf_out_arbiter
  import leaf_pkg::*;
(
  input logic               clk_bft,
  input logic               reset,
  leaf_out_arbiter_if.slave bus
);

  logic [NUM_OUT_PORTS-1:0] cfg_ok;
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [NUM_OUT_PORTS-1:0] gnt;
  logic                     found;
  logic                     slot_free;
  logic                     grant_en;
  logic [PTR_BITS-1:0]      rr_ptr;
  logic [PTR_BITS-1:0]      gnt_idx;

  logic [NUM_LEAF_BITS-1:0] dest_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dest_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq       [NUM_OUT_PORTS];
  logic [CRD_BITS-1:0]      credit    [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  word      [NUM_OUT_PORTS];

  logic [PACKET_BITS-1:0]   pkt_d;
  logic [PACKET_BITS-1:0]   pkt_p1;

  function automatic logic [CRD_BITS-1:0] sat_credit(input logic [CRD_BITS:0] sum);
    if (sum > (CRD_BITS+1)'(CREDIT_MAX)) return CRD_BITS'(CREDIT_MAX);
    return sum[CRD_BITS-1:0];
  endfunction

  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] idx);
    if (idx == PTR_BITS'(NUM_OUT_PORTS-1)) return '0;
    return idx + 1'b1;
  endfunction

  // Per-port configuration, credit and sequence state
  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
    logic                     hit_cfg;
    logic                     hit_crd;
    logic                     sent;
    logic [CRD_BITS:0]        crd_sum;
    logic                     cfg_ok_q;
    logic [CRD_BITS-1:0]      credit_q;
    logic [NUM_ADDR_BITS-1:0] seq_q;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] dport_q;

    assign word[i]      = bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign hit_cfg      = bus.cfg_we  && (bus.cfg_port == NUM_PORT_BITS'(i));
    assign hit_crd      = bus.crd_vld && (bus.crd_port == NUM_PORT_BITS'(i));
    assign sent         = grant_en && gnt[i];
    assign elig[i]      = bus.vld_user[i] && cfg_ok_q && (credit_q != '0);

    // Send and return net in one step; credit >= sent whenever sent is set.
    assign crd_sum = {1'b0, credit_q} - {{CRD_BITS{1'b0}}, sent}
                   + (hit_crd ? {1'b0, bus.crd_amt} : '0);

    always_ff @(posedge clk_bft or negedge reset) begin
      if (!reset) begin
        cfg_ok_q <= 1'b0;
        credit_q <= CRD_BITS'(CREDIT_MAX);
        seq_q    <= '0;
      end else begin
        if (hit_cfg) cfg_ok_q <= 1'b1;
        credit_q <= sat_credit(crd_sum);
        if (sent) seq_q <= seq_q + 1'b1;
      end
    end

    // Destination is only meaningful once cfg_ok is set, so it needs no reset.
    always_ff @(posedge clk_bft) begin
      if (hit_cfg) begin
        leaf_q  <= bus.cfg_leaf;
        dport_q <= bus.cfg_dport;
      end
    end

    assign cfg_ok[i]    = cfg_ok_q;
    assign credit[i]    = credit_q;
    assign seq[i]       = seq_q;
    assign dest_leaf[i] = leaf_q;
    assign dest_port[i] = dport_q;
  end

  rr_picker #(.N(NUM_OUT_PORTS)) u_picker (
    .req   (elig),
    .ptr   (rr_ptr),
    .gnt   (gnt),
    .found (found)
  );

  assign slot_free    = !pkt_p1[VALID_BIT] || bus.bft_rdy;
  assign grant_en     = slot_free && found;
  assign bus.ack_user = grant_en ? gnt : '0;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (gnt[i]) gnt_idx = PTR_BITS'(i);
    end
  end

  // Packet assembly; a busy slot holds the current packet, an idle free slot clears it
  always_comb begin
    pkt_d = pkt_p1;
    if (slot_free) begin
      pkt_d = '0;
      if (found) begin
        pkt_d[VALID_BIT]                        = 1'b1;
        pkt_d[LEAF_LSB    +: NUM_LEAF_BITS]     = dest_leaf[gnt_idx];
        pkt_d[DPORT_LSB   +: NUM_PORT_BITS]     = dest_port[gnt_idx];
        pkt_d[SEQ_LSB     +: NUM_ADDR_BITS]     = seq[gnt_idx];
        pkt_d[PAYLOAD_LSB +: PAYLOAD_BITS]      = word[gnt_idx];
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk_bft or negedge reset) begin
    if (!reset) begin
      pkt_p1 <= '0;
      rr_ptr <= '0;
    end else begin
      pkt_p1 <= pkt_d;
      if (grant_en) rr_ptr <= next_ptr(gnt_idx);
    end
  end

  assign bus.dout_bft = pkt_p1;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
module tb_leaf_out_arbiter;
  import leaf_pkg::*;

  logic clk_bft = 1'b0;
  logic reset   = 1'b0;
  int   tests   = 0;
  int   fails   = 0;

  leaf_out_arbiter_if bus ();

  leaf_out_arbiter dut (
    .clk_bft (clk_bft),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_bft = ~clk_bft;

  typedef struct {
    logic [3:0]             vld;
    logic                   rdy;
    logic [3:0]             ack;
    logic [PACKET_BITS-1:0] dout;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] word(input int p, input int k);
    return 32'hD000_0000 | (32'(p) << 12) | 32'(k);
  endfunction

  function automatic logic [PACKET_BITS-1:0] mk(input int l, input int d, input int s,
                                                input logic [31:0] pl);
    packet_t p;
    p.valid   = 1'b1;
    p.leaf    = NUM_LEAF_BITS'(l);
    p.dport   = NUM_PORT_BITS'(d);
    p.seq     = NUM_ADDR_BITS'(s);
    p.payload = pl;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_bft);
    #1;
  endtask

  task automatic set_words(input int k);
    for (int i = 0; i < NUM_OUT_PORTS; i++) bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS] = word(i, k);
  endtask

  task automatic cfg(input int p, input int l, input int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_port  = NUM_PORT_BITS'(p);
    bus.cfg_leaf  = NUM_LEAF_BITS'(l);
    bus.cfg_dport = NUM_PORT_BITS'(d);
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Drive vld on port 0 for n cycles, returning how many acks port 0 got.
  task automatic count_acks(input int n, output int cnt);
    cnt = 0;
    bus.vld_user = 4'b0001;
    for (int c = 0; c < n; c++) begin
      set_words(c);
      #2;
      if (bus.ack_user[0]) cnt++;
      tick();
    end
    bus.vld_user = 4'b0000;
  endtask

  initial begin
    int cnt;
    logic [PACKET_BITS-1:0] held;

    bus.din_user = '0;  bus.vld_user = '0;  bus.cfg_we = 1'b0;
    bus.cfg_port = '0;  bus.cfg_leaf = '0;  bus.cfg_dport = '0;
    bus.crd_vld  = 1'b0; bus.crd_port = '0; bus.crd_amt = '0;
    bus.bft_rdy  = 1'b0;

    // Vector table: state after configuring ports 0..3 to (leaf 5, port p+1)
    tbl[0]  = '{4'hF,    1'b1, 4'b0001, mk(5, 1, 0, word(0, 0))};
    tbl[1]  = '{4'hF,    1'b1, 4'b0010, mk(5, 2, 0, word(1, 1))};
    tbl[2]  = '{4'hF,    1'b1, 4'b0100, mk(5, 3, 0, word(2, 2))};
    tbl[3]  = '{4'hF,    1'b1, 4'b1000, mk(5, 4, 0, word(3, 3))};
    tbl[4]  = '{4'hF,    1'b1, 4'b0001, mk(5, 1, 1, word(0, 4))};
    tbl[5]  = '{4'hF,    1'b1, 4'b0010, mk(5, 2, 1, word(1, 5))};
    tbl[6]  = '{4'hF,    1'b1, 4'b0100, mk(5, 3, 1, word(2, 6))};
    tbl[7]  = '{4'hF,    1'b1, 4'b1000, mk(5, 4, 1, word(3, 7))};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, '0};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0010, mk(5, 2, 2, word(1, 9))};
    tbl[10] = '{4'b1010, 1'b1, 4'b1000, mk(5, 4, 2, word(3, 10))};
    tbl[11] = '{4'b0101, 1'b0, 4'b0000, mk(5, 4, 2, word(3, 10))};
    tbl[12] = '{4'b0101, 1'b1, 4'b0001, mk(5, 1, 2, word(0, 12))};
    tbl[13] = '{4'b0101, 1'b1, 4'b0100, mk(5, 3, 2, word(2, 13))};
    tbl[14] = '{4'b0001, 1'b1, 4'b0001, mk(5, 1, 3, word(0, 14))};
    tbl[15] = '{4'b0000, 1'b0, 4'b0000, mk(5, 1, 3, word(0, 14))};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, '0};

    // Reset state
    do_reset();
    bus.vld_user = 4'hF;
    bus.bft_rdy  = 1'b1;
    #2;
    chk("reset_dout", bus.dout_bft, '0);
    chk("reset_ack_unconfigured", bus.ack_user, 4'b0000);
    tick();
    chk("reset_dout_idle", bus.dout_bft, '0);
    bus.vld_user = '0;

    for (int p = 0; p < NUM_OUT_PORTS; p++) cfg(p, 5, p + 1);

    // Table-driven round-robin / hold / clear vectors
    for (int k = 0; k < 17; k++) begin
      bus.vld_user = tbl[k].vld;
      bus.bft_rdy  = tbl[k].rdy;
      set_words(k);
      #2;
      chk($sformatf("tbl%0d_ack", k), bus.ack_user, tbl[k].ack);
      tick();
      chk($sformatf("tbl%0d_dout", k), bus.dout_bft, tbl[k].dout);
    end

    // Backpressure: packet held 5 cycles, next grant loads as soon as rdy returns
    bus.vld_user = 4'b0001;
    bus.bft_rdy  = 1'b1;
    set_words(20);
    tick();
    held = mk(5, 1, 4, word(0, 20));
    chk("bp_load", bus.dout_bft, held);
    bus.vld_user = 4'b0011;
    bus.bft_rdy  = 1'b0;
    set_words(21);
    for (int c = 0; c < 5; c++) begin
      #2;
      chk($sformatf("bp_ack_low%0d", c), bus.ack_user, 4'b0000);
      tick();
      chk($sformatf("bp_hold%0d", c), bus.dout_bft, held);
    end
    bus.bft_rdy = 1'b1;
    #2;
    chk("bp_release_ack", bus.ack_user, 4'b0010);
    tick();
    chk("bp_release_dout", bus.dout_bft, mk(5, 2, 3, word(1, 21)));
    bus.vld_user = '0;
    tick();

    // Unconfigured port never acked; out-of-range cfg_port ignored
    do_reset();
    bus.bft_rdy = 1'b1;
    cfg(0, 5, 1);
    cfg(1, 5, 2);
    cfg(3, 5, 4);
    cfg(6, 3, 7);
    bus.vld_user = 4'b0100;
    set_words(30);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("uncfg_ack%0d", c), bus.ack_user, 4'b0000);
      tick();
    end
    bus.cfg_we = 1'b1; bus.cfg_port = 4'd2; bus.cfg_leaf = 5'd3; bus.cfg_dport = 4'd7;
    #2;
    chk("cfg_write_cycle_ack", bus.ack_user, 4'b0000);
    tick();
    bus.cfg_we = 1'b0;
    #2;
    chk("cfg_next_cycle_ack", bus.ack_user, 4'b0100);
    tick();
    chk("cfg_first_pkt", bus.dout_bft, mk(3, 7, 0, word(2, 30)));
    // Rewriting keeps seq; new destination applies from the following grant
    bus.cfg_we = 1'b1; bus.cfg_port = 4'd2; bus.cfg_leaf = 5'd4; bus.cfg_dport = 4'd1;
    tick();
    bus.cfg_we = 1'b0;
    chk("recfg_old_dest", bus.dout_bft, mk(3, 7, 1, word(2, 30)));
    tick();
    chk("recfg_new_dest", bus.dout_bft, mk(4, 1, 2, word(2, 30)));
    bus.vld_user = '0;

    // Credit exhaustion and return
    do_reset();
    bus.bft_rdy = 1'b1;
    cfg(0, 1, 2);
    count_acks(70, cnt);
    chk("credit_exhaust_64", cnt, 64);
    bus.crd_vld = 1'b1; bus.crd_port = 4'd8; bus.crd_amt = 7'd8;
    tick();
    bus.crd_vld = 1'b0;
    count_acks(5, cnt);
    chk("credit_bad_port_ignored", cnt, 0);
    bus.crd_vld = 1'b1; bus.crd_port = 4'd0; bus.crd_amt = 7'd8;
    tick();
    bus.crd_vld = 1'b0;
    count_acks(20, cnt);
    chk("credit_return_8", cnt, 8);

    // Saturation: 60 + 10 clamps to 64
    do_reset();
    cfg(0, 1, 2);
    count_acks(4, cnt);
    chk("sat_pre_send", cnt, 4);
    bus.crd_vld = 1'b1; bus.crd_port = 4'd0; bus.crd_amt = 7'd10;
    tick();
    bus.crd_vld = 1'b0;
    count_acks(80, cnt);
    chk("sat_clamp_64", cnt, 64);

    // Seq wrap on port 1 with a credit returned every cycle alongside each send
    do_reset();
    cfg(1, 2, 9);
    bus.vld_user = 4'b0010;
    bus.crd_vld = 1'b1; bus.crd_port = 4'd1; bus.crd_amt = 7'd1;
    for (int k = 0; k < 130; k++) begin
      set_words(k);
      #2;
      chk($sformatf("wrap_ack%0d", k), bus.ack_user, 4'b0010);
      tick();
      chk($sformatf("wrap_pkt%0d", k), bus.dout_bft, mk(2, 9, k % 128, word(1, k)));
    end
    bus.crd_vld  = 1'b0;
    bus.vld_user = '0;

    // Asynchronous reset with a packet held
    bus.bft_rdy = 1'b0;
    tick();
    chk("pre_reset_held_valid", bus.dout_bft[VALID_BIT], 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_dout", bus.dout_bft, '0);
    tick();
    reset = 1'b1;
    bus.bft_rdy  = 1'b1;
    bus.vld_user = 4'hF;
    #2;
    chk("post_reset_need_cfg", bus.ack_user, 4'b0000);
    tick();
    bus.vld_user = '0;
    for (int p = 0; p < NUM_OUT_PORTS; p++) cfg(p, 5, p + 1);
    bus.vld_user = 4'hF;
    set_words(40);
    #2;
    chk("post_reset_ptr0_ack", bus.ack_user, 4'b0001);
    tick();
    chk("post_reset_p0_pkt", bus.dout_bft, mk(5, 1, 0, word(0, 40)));
    #2;
    chk("post_reset_p1_ack", bus.ack_user, 4'b0010);
    tick();
    chk("post_reset_p1_seq0", bus.dout_bft, mk(5, 2, 0, word(1, 40)));
    bus.vld_user = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
